pio_bidir_seq: RTL

- Half-duplex single-wire sequencer that sits directly upstream of a MachXO2 BB bidirectional pad buffer.
- Drives the BB I (data) and T (tristate, 1 = hi-Z) inputs and consumes the BB O output.
- On each transaction it shifts a DATA_W-bit word out on the pad, releases the pad for a turnaround window, then samples a DATA_W-bit response from the same pad.
- Used by hardware tests to exercise the BB path with real sequential traffic instead of constant ties.

---
 rtl/pio_bidir_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pio_bidir_seq.sv
// Half-duplex single-wire sequencer in front of a MachXO2 BB pad buffer.
// Optional odd-parity framing: define PIO_BIDIR_SEQ_PARITY_EN.
module pio_bidir_seq #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int TURN_CLKS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              bb_i,
  output logic              bb_t,
  input  logic              bb_o
);

`ifdef PIO_BIDIR_SEQ_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NB + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NB - 1);
  localparam logic [7:0]    TURN_LAST = 8'(TURN_CLKS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_TURN = 3'd3;
  localparam logic [2:0] S_RX   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [7:0]    tcnt;
  logic [NB-1:0] txsh;
  logic [NB-1:0] rxsh;
  logic [1:0]    sync;

  logic [NB-1:0] frame;
  logic [NB-1:0] tx_next;
  logic [NB-1:0] rx_next;
  logic          bit_end;
  logic          last_bit;

  always_comb begin
    frame = '0;
`ifdef PIO_BIDIR_SEQ_PARITY_EN
    frame = {~^tx_data, tx_data};
`else
    frame = tx_data;
`endif
  end

  assign tx_next  = txsh >> 1;
  assign rx_next  = NB'({sync[1], rxsh} >> 1);
  assign bit_end  = (cnt == CNT_LAST);
  assign last_bit = (idx == IDX_LAST);

  // bb_o is unrelated to clk: two flops before any decision uses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], bb_o};
    end
  end

  // LOAD spends one cycle after acceptance so pad outputs start on a fresh bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      tcnt    <= '0;
      txsh    <= '0;
      rxsh    <= '0;
      bb_i    <= 1'b1;
      bb_t    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
`ifdef PIO_BIDIR_SEQ_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            txsh  <= frame;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= S_TX;
          bb_t  <= 1'b0;
          bb_i  <= txsh[0];
          busy  <= 1'b1;
          cnt   <= '0;
          idx   <= '0;
        end
        S_TX: begin
          if (bit_end) begin
            cnt  <= '0;
            txsh <= tx_next;
            if (last_bit) begin
              idx   <= '0;
              tcnt  <= '0;
              bb_t  <= 1'b1;
              bb_i  <= 1'b1;
              state <= S_TURN;
            end else begin
              idx  <= idx + 1'b1;
              bb_i <= tx_next[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (tcnt == TURN_LAST) begin
            tcnt  <= '0;
            cnt   <= '0;
            idx   <= '0;
            state <= S_RX;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RX: begin
          if (cnt == CNT_MID) begin
            rxsh <= rx_next;
          end
          if (bit_end) begin
            cnt <= '0;
            if (last_bit) begin
              idx     <= '0;
              state   <= S_DONE;
              done    <= 1'b1;
              rx_data <= rxsh[DATA_W-1:0];
`ifdef PIO_BIDIR_SEQ_PARITY_EN
              rx_parity_err <= ~^rxsh;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef PIO_BIDIR_SEQ_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule
